// File: rtl/sdiv_32_32_if.sv
// sdiv_32_32_if: operand/result bundle for the iterative 32-bit divider.
//   ai, bi : 33-bit signed operands (sign-extended for DIV/REM,
//            zero-extended for DIVU/REMU)
//   req    : operation request, level
//   rdy    : one-cycle pulse, q/rem valid from that cycle on
//   busy   : operation in flight
//   q, rem : quotient and remainder, low 32 bits
// master = requester side, slave = divider side.
interface sdiv_32_32_if;
    logic [32:0] ai;
    logic [32:0] bi;
    logic        req;
    logic        rdy;
    logic        busy;
    logic [31:0] q;
    logic [31:0] rem;

    modport master (
        output ai, bi, req,
        input  rdy, busy, q, rem
    );

    modport slave (
        input  ai, bi, req,
        output rdy, busy, q, rem
    );
endinterface

// File: rtl/sdiv_32_32.sv
// sdiv_32_32: iterative signed/unsigned 32-bit divider (RISC-V M extension).
// Magnitudes are divided by radix-2^BITS_PER_CYCLE restoring division,
// then RISC-V sign rules are applied (quotient sign = sign_a ^ sign_b,
// remainder sign follows the dividend). Divide-by-zero and |a| < |b|
// finish directly from CHECK.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : sdiv_32_32_if.slave (ai, bi, req in; rdy, busy, q, rem out)
// BITS_PER_CYCLE must be 1, 2 or 4.
module sdiv_32_32 #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    sdiv_32_32_if.slave  bus
);

    localparam int         N_ITER    = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_ITER = 5'(N_ITER - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;
    logic [31:0] bu_reg;
    // Holds |a| in CHECK, then doubles as the dividend/quotient shift
    // register in CALC: dividend bits leave at the top, quotient bits
    // enter at the bottom, so after the last iteration it is the quotient.
    logic [31:0] dvd_reg;
    logic [31:0] prem_reg;
    logic [4:0]  cnt_reg;
    logic        rdy_reg;
    logic        busy_reg;
    logic [31:0] q_reg;
    logic [31:0] rem_reg;

    // Magnitudes: a negative operand is at most 2^31 in magnitude, so a
    // 32-bit negate of the low bits is exact.
    logic [31:0] ai_mag;
    logic [31:0] bi_mag;
    assign ai_mag = bus.ai[32] ? (32'd0 - bus.ai[31:0]) : bus.ai[31:0];
    assign bi_mag = bus.bi[32] ? (32'd0 - bus.bi[31:0]) : bus.bi[31:0];

    // Remainder for the fast path: the dividend itself with its sign.
    logic [31:0] fast_rem;
    assign fast_rem = sign_a_reg ? (32'd0 - dvd_reg) : dvd_reg;

    // Unrolled restoring-division stages, one per quotient bit per cycle.
    logic [31:0] stage_rem [BITS_PER_CYCLE+1];
    logic [31:0] stage_dvd [BITS_PER_CYCLE+1];

    assign stage_rem[0] = prem_reg;
    assign stage_dvd[0] = dvd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi = gi + 1) begin : g_stage
            logic [32:0] shifted;
            logic        ge;
            assign shifted = {stage_rem[gi], stage_dvd[gi][31]};
            assign ge      = (shifted >= {1'b0, bu_reg});
            // When ge, the true difference is below bu and fits 32 bits,
            // so a 32-bit subtract of the low bits is exact.
            assign stage_rem[gi+1] = ge ? (shifted[31:0] - bu_reg) : shifted[31:0];
            assign stage_dvd[gi+1] = {stage_dvd[gi][30:0], ge};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            bu_reg     <= 32'd0;
            dvd_reg    <= 32'd0;
            prem_reg   <= 32'd0;
            cnt_reg    <= 5'd0;
            rdy_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            q_reg      <= 32'd0;
            rem_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        sign_a_reg <= bus.ai[32];
                        sign_b_reg <= bus.bi[32];
                        dvd_reg    <= ai_mag;
                        bu_reg     <= bi_mag;
                        busy_reg   <= 1'b1;
                        state_reg  <= CHECK;
                    end
                end
                CHECK: begin
                    if (bu_reg == 32'd0) begin
                        q_reg     <= 32'hFFFF_FFFF;
                        rem_reg   <= fast_rem;
                        rdy_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else if (dvd_reg < bu_reg) begin
                        q_reg     <= 32'd0;
                        rem_reg   <= fast_rem;
                        rdy_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        prem_reg  <= 32'd0;
                        cnt_reg   <= 5'd0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    prem_reg <= stage_rem[BITS_PER_CYCLE];
                    dvd_reg  <= stage_dvd[BITS_PER_CYCLE];
                    cnt_reg  <= cnt_reg + 5'd1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    q_reg     <= (sign_a_reg ^ sign_b_reg) ? (32'd0 - dvd_reg) : dvd_reg;
                    rem_reg   <= sign_a_reg ? (32'd0 - prem_reg) : prem_reg;
                    rdy_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= DONE;
                end
                DONE: begin
                    rdy_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    rdy_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.rdy  = rdy_reg;
    assign bus.busy = busy_reg;
    assign bus.q    = q_reg;
    assign bus.rem  = rem_reg;

endmodule

// File: tb/tb_sdiv_32_32.sv
// tb_sdiv_32_32: self-checking bench for sdiv_32_32 with BITS_PER_CYCLE
// 1 and 4 side by side. Expected results come from 64-bit integer
// division/modulo with RISC-V divide-by-zero rules.
module tb_sdiv_32_32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdiv_32_32_if bus1();
    sdiv_32_32_if bus4();

    sdiv_32_32 #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    sdiv_32_32 #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the 33-bit operands.
    task automatic model(input logic [32:0] a, input logic [32:0] b,
                         output logic [31:0] eq, output logic [31:0] er,
                         output logic fast);
        longint sa, sb, qq, rr, ma, mb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            eq   = 32'hFFFF_FFFF;
            er   = a[31:0];
            fast = 1'b1;
        end else begin
            qq   = sa / sb;
            rr   = sa % sb;
            eq   = qq[31:0];
            er   = rr[31:0];
            ma   = (sa < 0) ? -sa : sa;
            mb   = (sb < 0) ? -sb : sb;
            fast = (ma < mb);
        end
    endtask

    // One operation on DUT1 (and DUT4 if use4): checks latency, result,
    // busy/rdy relation, and that rdy is a single-cycle pulse.
    task automatic run_op(input logic [32:0] a, input logic [32:0] b,
                          input logic use4, input string tag);
        logic [31:0] eq, er;
        logic        fast;
        int ph1, ph4;
        logic busy_ok1, busy_ok4;
        model(a, b, eq, er, fast);
        bus1.ai = a; bus1.bi = b; bus1.req = 1'b1;
        if (use4) begin
            bus4.ai = a; bus4.bi = b; bus4.req = 1'b1;
        end
        ph1 = 0;
        ph4 = use4 ? 0 : 2;
        busy_ok1 = 1'b1;
        busy_ok4 = 1'b1;
        for (int n = 0; n < 80 && !(ph1 == 2 && ph4 == 2); n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                // operands after E0 must be ignored
                bus1.ai = {1'b0, $urandom}; bus1.bi = {1'b0, $urandom};
                bus4.ai = {1'b0, $urandom}; bus4.bi = {1'b0, $urandom};
            end
            if (ph1 == 1) begin
                chk({tag, "/pulse1"}, 64'(bus1.rdy), 64'd0);
                ph1 = 2;
            end else if (ph1 == 0) begin
                if (bus1.busy !== !bus1.rdy) busy_ok1 = 1'b0;
                if (bus1.rdy === 1'b1) begin
                    chk({tag, "/lat1"}, 64'(n), fast ? 64'd1 : 64'd34);
                    chk({tag, "/q1"}, 64'(bus1.q), 64'(eq));
                    chk({tag, "/rem1"}, 64'(bus1.rem), 64'(er));
                    bus1.req = 1'b0;
                    ph1 = 1;
                end
            end
            if (ph4 == 1) begin
                chk({tag, "/pulse4"}, 64'(bus4.rdy), 64'd0);
                ph4 = 2;
            end else if (ph4 == 0) begin
                if (bus4.busy !== !bus4.rdy) busy_ok4 = 1'b0;
                if (bus4.rdy === 1'b1) begin
                    chk({tag, "/lat4"}, 64'(n), fast ? 64'd1 : 64'd10);
                    chk({tag, "/q4"}, 64'(bus4.q), 64'(eq));
                    chk({tag, "/rem4"}, 64'(bus4.rem), 64'(er));
                    bus4.req = 1'b0;
                    ph4 = 1;
                end
            end
        end
        chk({tag, "/done1"}, 64'(ph1), 64'd2);
        chk({tag, "/busy1"}, 64'(busy_ok1), 64'd1);
        if (use4) begin
            chk({tag, "/done4"}, 64'(ph4), 64'd2);
            chk({tag, "/busy4"}, 64'(busy_ok4), 64'd1);
        end
        $display("op %s: ai=%h bi=%h -> exp q=%h rem=%h got q=%h rem=%h",
                 tag, a, b, eq, er, bus1.q, bus1.rem);
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;
        logic [32:0] ta, tb;

        bus1.ai = '0; bus1.bi = '0; bus1.req = 1'b0;
        bus4.ai = '0; bus4.bi = '0; bus4.req = 1'b0;

        // Reset state
        #2;
        chk("rst/rdy", 64'(bus1.rdy), 64'd0);
        chk("rst/busy", 64'(bus1.busy), 64'd0);
        chk("rst/q", 64'(bus1.q), 64'd0);
        chk("rst/rem", 64'(bus1.rem), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(33'd100, 33'd7, 1'b1, "100/7");
        run_op(33'h1_FFFF_FF9C, 33'd7, 1'b1, "-100/7");
        run_op(33'd100, 33'h1_FFFF_FFF9, 1'b1, "100/-7");
        run_op(33'h0_FFFF_FFFF, 33'h0_0000_0010, 1'b1, "unsigned");
        run_op(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b1, "overflow");
        run_op(33'd5, 33'd0, 1'b1, "div0");
        run_op(33'h1_FFFF_FFFD, 33'd10, 1'b1, "small");

        // Reset during the 10th CALC iteration of DUT1
        bus1.ai = 33'd100; bus1.bi = 33'd7; bus1.req = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst/busy_before", 64'(bus1.busy), 64'd1);
        rst = 1'b1;
        bus1.req = 1'b0;
        #1;
        chk("midrst/rdy", 64'(bus1.rdy), 64'd0);
        chk("midrst/busy", 64'(bus1.busy), 64'd0);
        chk("midrst/q", 64'(bus1.q), 64'd0);
        chk("midrst/rem", 64'(bus1.rem), 64'd0);
        chk("midrst/q4", 64'(bus4.q), 64'd0);
        $display("op midrst: rdy=%b busy=%b q=%h rem=%h", bus1.rdy, bus1.busy, bus1.q, bus1.rem);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back with req held high on DUT1
        bus1.ai = 33'd20; bus1.bi = 33'd3; bus1.req = 1'b1;
        lat = -1;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk); #1;
            if (bus1.rdy === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk("b2b/lat_a", 64'(lat), 64'd34);
        chk("b2b/q_a", 64'(bus1.q), 64'd6);
        chk("b2b/rem_a", 64'(bus1.rem), 64'd2);
        $display("op b2b_a: 20/3 -> q=%h rem=%h lat=%0d", bus1.q, bus1.rem, lat);
        bus1.ai = 33'd9; bus1.bi = 33'd9;
        lat = -1;
        for (int n = 1; n < 80; n++) begin
            @(posedge clk); #1;
            if (bus1.rdy === 1'b1) begin
                lat = n;
                break;
            end
        end
        // DONE->IDLE edge, then E0, then 34 edges
        chk("b2b/lat_b", 64'(lat), 64'd36);
        chk("b2b/q_b", 64'(bus1.q), 64'd1);
        chk("b2b/rem_b", 64'(bus1.rem), 64'd0);
        $display("op b2b_b: 9/9 -> q=%h rem=%h lat=%0d", bus1.q, bus1.rem, lat);
        bus1.req = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Randomized operations against the model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = $urandom;
                2: rb = 32'd0;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                ta = {ra[31], ra};
                tb = {rb[31], rb};
            end else begin
                ta = {1'b0, ra};
                tb = {1'b0, rb};
            end
            run_op(ta, tb, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdiv_32_32.md
Name: sdiv_32_32

Overview:
- Iterative signed/unsigned 32-bit divider for the core's M-extension datapath. It is the inverse-operation partner of the 33x33 multiplier and uses the same operand format and req/rdy handshake.
- Operands arrive as 33-bit signed values. The caller sign-extends for DIV/REM and zero-extends for DIVU/REMU.
- Computes magnitude quotient and remainder by radix-2^B restoring division, then applies RISC-V sign rules. Divide-by-zero and |a|<|b| take a fast path.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle. Legal values: 1, 2, 4. CALC length = 32/BITS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- ai  in  33  signed dividend
- bi  in  33  signed divisor
- req  in  1  operation request, level
- rdy  out  1  one-cycle pulse; q/rem valid from this cycle on
- busy  out  1  high while an operation is in flight (states CHECK, CALC, FIX)
- q  out  32  quotient, low 32 bits
- rem  out  32  remainder, low 32 bits

Behaviour:
- Reset (async, any state): FSM=IDLE, rdy=0, busy=0, q=0, rem=0, iteration counter=0, partial remainder cleared.
- States: IDLE, CHECK, CALC, FIX, DONE.
- IDLE, edge E0 with req=1:
  - latch sign_a=ai[32], sign_b=bi[32];
  - latch au=|ai|[31:0], bu=|bi|[31:0] (both fit in 32 bits);
  - go to CHECK.
  - ai/bi changes after E0 are ignored.
- CHECK, edge E1:
  - bu==0: q=32'hFFFF_FFFF, rem=ai[31:0] as latched, rdy<=1, go to DONE.
  - else au<bu: q=0, rem=sign_a ? -au : au, rdy<=1, go to DONE.
  - else go to CALC, counter=0.
- CALC: each edge shifts BITS_PER_CYCLE dividend bits into the partial remainder. For each bit: trial subtract bu; on no borrow keep the difference and set the quotient bit to 1. Counter increments. Leave to FIX after 32/BITS_PER_CYCLE edges.
- FIX, one edge:
  - q = (sign_a^sign_b) ? -quot : quot
  - rem = sign_a ? -prem : prem (remainder sign follows the dividend)
  - rdy<=1, go to DONE.
- DONE: rdy=1 for exactly this cycle. Next edge: rdy<=0, go to IDLE.
- Latency, counting edges after E0 until rdy is high:
  - fast path: 1
  - full path: 2 + 32/BITS_PER_CYCLE (34 for the default).
- Overflow case (ai=-2^31, bi=-1, signed): needs no special handling. Magnitude 2^31 yields q=32'h8000_0000, rem=0.
- Handshake:
  - Requester holds req high until it sees rdy, then deasserts req in the cycle after rdy.
  - If req is still high when the FSM is back in IDLE, a new operation starts; back-to-back operations are legal.
  - req going low mid-operation does not abort; the result still completes with a rdy pulse.
- q/rem hold their last value until the next result write. They are written only on the edge that sets rdy.
- busy=0 in IDLE and DONE.

Test Plan:
- ai=100, bi=7 -> q=14, rem=2; rdy high 34 edges after E0 for exactly one cycle; busy high during CHECK..FIX.
- ai=-100 (33'h1_FFFF_FF9C), bi=7 -> q=32'hFFFF_FFF2, rem=32'hFFFF_FFFE. ai=100, bi=-7 -> q=32'hFFFF_FFF2, rem=2.
- Unsigned/overflow:
  - ai=33'h0_FFFF_FFFF, bi=33'h0_0000_0010 -> q=32'h0FFF_FFFF, rem=32'hF.
  - ai=33'h1_8000_0000, bi=33'h1_FFFF_FFFF -> q=32'h8000_0000, rem=0.
- Fast paths, each with rdy one edge after E0:
  - ai=5, bi=0 -> q=32'hFFFF_FFFF, rem=5.
  - ai=-3, bi=10 -> q=0, rem=32'hFFFF_FFFD.
- Reset and back-to-back:
  - assert rst during CALC (10th iteration) -> rdy=0, busy=0, q=rem=0 immediately.
  - after reset release, hold req high for two ops (20/3 then 9/9) -> results 6 r2 then 1 r0; second op's E0 is the cycle after DONE.
- Repeat the first and third scenarios with BITS_PER_CYCLE=4 -> identical results, full-path latency 10.
